// File: rtl/apb_remote_poller_pkg.sv
// Shared types for the remote APB poller: FSM states, the latched request and strobe constants.
package apb_poller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        is_poll;
    } req_t;

    localparam logic [3:0] APB_STRB_ALL = 4'hF;
    localparam logic [3:0] APB_STRB_NONE = 4'h0;

endpackage

// File: rtl/apb_remote_poller_if.sv
// APB bus bundle between the poller (requester) and the bridge completer port.
interface apb_remote_poller_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_poll_timer.sv
// Heartbeat interval timer: reloading down-counter, one-cycle expire pulse at terminal count.
module apb_poll_timer #(
    parameter int INTERVAL = 156250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(INTERVAL);
    localparam logic [W-1:0] RELOAD = W'(INTERVAL - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (!en || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = en && (cnt == '0);
endmodule

// File: rtl/apb_remote_poller.sv
// APB requester serving host commands and a periodic heartbeat read with access timeout.
// state  | meaning
// IDLE   | accept host command (priority) or pending heartbeat
// SETUP  | psel high, penable low, one cycle
// ACCESS | wait for pready or timeout
// DONE   | one-cycle response pulse, status update
module apb_remote_poller
    import apb_poller_pkg::*;
#(
    parameter int          POLL_INTERVAL  = 156250,
    parameter logic [31:0] POLL_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          FAIL_THRESHOLD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        rsp_is_poll,
    apb_remote_poller_if.master apb,
    output logic        link_up,
    output logic [15:0] poll_count,
    output logic [15:0] timeout_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = $clog2(FAIL_THRESHOLD + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    req_t          req;
    logic [TW-1:0] to_cnt;
    logic [31:0]   cap_rdata;
    logic          cap_err, cap_timeout;
    logic          poll_pending, poll_expire;
    logic [FW-1:0] fail_cnt;
    logic          accept_cmd, accept_poll, access_ok, access_abort, busy;

    apb_poll_timer #(.INTERVAL(POLL_INTERVAL)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (poll_en),
        .expire (poll_expire)
    );

    always_comb begin
        state_nxt    = state;
        accept_cmd   = 1'b0;
        accept_poll  = 1'b0;
        access_ok    = 1'b0;
        access_abort = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept_cmd = 1'b1;
                    state_nxt  = SETUP;
                end else if (poll_pending) begin
                    accept_poll = 1'b1;
                    state_nxt   = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // pready on the expiry cycle still wins over the abort
                access_ok    = apb.pready;
                access_abort = !apb.pready && (to_cnt == TO_LAST);
                if (access_ok || access_abort) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req           <= '0;
            to_cnt        <= '0;
            cap_rdata     <= '0;
            cap_err       <= 1'b0;
            cap_timeout   <= 1'b0;
            poll_pending  <= 1'b0;
            link_up       <= 1'b0;
            fail_cnt      <= '0;
            poll_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (accept_cmd) begin
                req <= '{addr: cmd_addr, wdata: (cmd_write ? cmd_wdata : 32'h0),
                         write: cmd_write, is_poll: 1'b0};
            end else if (accept_poll) begin
                req <= '{addr: POLL_ADDR, wdata: 32'h0, write: 1'b0, is_poll: 1'b1};
            end

            to_cnt <= (state == ACCESS) ? to_cnt + TW'(1) : '0;

            if (access_ok) begin
                cap_rdata   <= req.write ? 32'h0 : apb.prdata;
                cap_err     <= apb.pslverr;
                cap_timeout <= 1'b0;
            end else if (access_abort) begin
                cap_rdata   <= 32'h0;
                cap_err     <= 1'b0;
                cap_timeout <= 1'b1;
            end

            // a further expiry while one is already pending is simply absorbed
            if (!poll_en)          poll_pending <= 1'b0;
            else if (accept_poll)  poll_pending <= 1'b0;
            else if (poll_expire)  poll_pending <= 1'b1;

            if (state == DONE) begin
                if (cap_timeout && timeout_count != 16'hFFFF)
                    timeout_count <= timeout_count + 16'd1;
                if (req.is_poll) begin
                    poll_count <= poll_count + 16'd1;
                    if (!cap_err && !cap_timeout) begin
                        link_up  <= 1'b1;
                        fail_cnt <= '0;
                    end else begin
                        if (fail_cnt != FW'(FAIL_THRESHOLD)) fail_cnt <= fail_cnt + FW'(1);
                        if (fail_cnt >= FW'(FAIL_THRESHOLD - 1)) link_up <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy        = (state == SETUP) || (state == ACCESS);
    assign cmd_ready   = (state == IDLE) && !rst;

    assign apb.psel    = busy;
    assign apb.penable = (state == ACCESS);
    assign apb.paddr   = busy ? req.addr : 32'h0;
    assign apb.pwrite  = busy && req.write;
    assign apb.pwdata  = busy ? req.wdata : 32'h0;
    assign apb.pstrb   = (busy && req.write) ? APB_STRB_ALL : APB_STRB_NONE;

    assign rsp_valid   = (state == DONE);
    assign rsp_rdata   = rsp_valid ? cap_rdata : 32'h0;
    assign rsp_err     = rsp_valid && cap_err;
    assign rsp_timeout = rsp_valid && cap_timeout;
    assign rsp_is_poll = rsp_valid && req.is_poll;
endmodule

// File: tb/tb_apb_remote_poller.sv
// Directed bench for apb_remote_poller: host reads/writes, timeouts, heartbeat link tracking, reset.
module tb_apb_remote_poller;
    localparam int          POLL_INTERVAL  = 100;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam int          FAIL_THRESHOLD = 3;
    localparam logic [31:0] POLL_ADDR      = 32'h0000_0C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        poll_en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_is_poll, link_up;
    logic [31:0] rsp_rdata;
    logic [15:0] poll_count, timeout_count;

    apb_remote_poller_if apb();

    apb_remote_poller #(
        .POLL_INTERVAL  (POLL_INTERVAL),
        .POLL_ADDR      (POLL_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FAIL_THRESHOLD (FAIL_THRESHOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .poll_en       (poll_en),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .rsp_timeout   (rsp_timeout),
        .rsp_is_poll   (rsp_is_poll),
        .apb           (apb.master),
        .link_up       (link_up),
        .poll_count    (poll_count),
        .timeout_count (timeout_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc_abs = 0;

    logic        cfg_hang = 1'b0;
    logic        cfg_err = 1'b0;
    int          cfg_wait = 0;
    logic [31:0] cfg_rdata = 32'h0;
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    // Completer model: pready after cfg_wait ACCESS cycles unless hung.
    always @(negedge clk) begin
        if (apb.psel && apb.penable) begin
            apb.pready = !cfg_hang && (acc_cnt >= cfg_wait);
            acc_cnt    = acc_cnt + 1;
        end else begin
            apb.pready = 1'b0;
            acc_cnt    = 0;
        end
        apb.prdata  = apb.pready ? cfg_rdata : 32'h0;
        apb.pslverr = apb.pready && cfg_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int acc);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        chk("cmd_ready_at_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        lat = 1;
        acc = 0;
        while (!rsp_valid && lat < 100) begin
            if (apb.psel) begin
                chk("paddr_stable", apb.paddr, a);
                chk("pwdata_stable", apb.pwdata, w ? d : 32'h0);
                chk("pwrite", apb.pwrite, w);
                chk("pstrb", apb.pstrb, w ? 32'hF : 32'h0);
                if (apb.penable) acc++;
            end
            @(negedge clk);
            lat++;
        end
        chk("cmd_rsp_seen", rsp_valid, 1);
    endtask

    task automatic wait_rsp(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (apb.psel) chk("poll_paddr", apb.paddr, POLL_ADDR);
        end while (!rsp_valid && c < 300);
        chk("poll_rsp_seen", rsp_valid, 1);
    endtask

    initial begin
        int lat, acc, c, t_en, seen;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_poll_count", poll_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // zero-wait host read
        cfg_wait  = 0;
        cfg_rdata = 32'hDEADBEEF;
        run_cmd(1'b0, 32'h0000_0040, 32'h0, lat, acc);
        chk("rd_latency", lat, 3);
        chk("rd_access_cycles", acc, 1);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", rsp_err, 0);
        chk("rd_is_poll", rsp_is_poll, 0);
        chk("rd_timeout", rsp_timeout, 0);
        @(negedge clk);
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("back_to_idle", cmd_ready, 1);

        // host write, completer waits 5 cycles
        cfg_wait = 5;
        run_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, lat, acc);
        chk("wr_latency", lat, 8);
        chk("wr_access_cycles", acc, 6);
        chk("wr_rdata_zero", rsp_rdata, 0);
        chk("wr_err", rsp_err, 0);
        @(negedge clk);

        // host read with slave error
        cfg_wait  = 0;
        cfg_err   = 1'b1;
        cfg_rdata = 32'h0BAD_0BAD;
        run_cmd(1'b0, 32'h0000_0044, 32'h0, lat, acc);
        chk("slverr_latency", lat, 3);
        chk("slverr_err", rsp_err, 1);
        chk("slverr_rdata", rsp_rdata, 32'h0BAD_0BAD);
        @(negedge clk);
        cfg_err = 1'b0;
        chk("host_no_link_effect", link_up, 0);

        // host read that never gets pready
        cfg_hang = 1'b1;
        run_cmd(1'b0, 32'h0000_0020, 32'h0, lat, acc);
        chk("to_access_cycles", acc, 16);
        chk("to_latency", lat, 18);
        chk("to_flag", rsp_timeout, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_err", rsp_err, 0);
        @(negedge clk);
        cfg_hang = 1'b0;
        chk("to_count_host", timeout_count, 1);
        chk("to_host_link", link_up, 0);
        chk("to_host_poll_count", poll_count, 0);

        // heartbeat polling, healthy completer
        cfg_rdata = 32'hA5A5_0001;
        poll_en   = 1'b1;
        t_en      = cyc_abs;
        wait_rsp(c);
        chk("poll1_time", c, 103);
        chk("poll1_is_poll", rsp_is_poll, 1);
        chk("poll1_rdata", rsp_rdata, 32'hA5A5_0001);
        wait_rsp(c);
        chk("poll2_interval", c, 100);
        wait_rsp(c);
        chk("poll3_interval", c, 100);
        @(negedge clk);
        chk("poll_link_up", link_up, 1);
        chk("poll_count_3", poll_count, 3);

        // three consecutive timed-out heartbeats
        cfg_hang = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(c);
            chk("poll_fail_timeout", rsp_timeout, 1);
            chk("poll_fail_is_poll", rsp_is_poll, 1);
            @(negedge clk);
            chk("poll_fail_link", link_up, (i < FAIL_THRESHOLD - 1) ? 1 : 0);
        end
        chk("fail_timeout_count", timeout_count, 4);
        chk("fail_poll_count", poll_count, 6);
        cfg_hang = 1'b0;
        wait_rsp(c);
        chk("recover_timeout", rsp_timeout, 0);
        @(negedge clk);
        chk("recover_link", link_up, 1);
        chk("recover_poll_count", poll_count, 7);

        // host command on the cycle the next heartbeat becomes pending
        while (cyc_abs - t_en < 800) @(negedge clk);
        cfg_rdata = 32'h0000_0080;
        run_cmd(1'b0, 32'h0000_0080, 32'h0, lat, acc);
        chk("coll_host_latency", lat, 3);
        chk("coll_host_first", rsp_is_poll, 0);
        wait_rsp(c);
        chk("coll_poll_follows", c, 4);
        chk("coll_poll_is_poll", rsp_is_poll, 1);
        @(negedge clk);
        chk("coll_poll_count", poll_count, 8);

        // reset in the middle of an ACCESS phase
        poll_en  = 1'b0;
        cfg_hang = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0030;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_access_penable", apb.penable, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_psel", apb.psel, 0);
        chk("rst_mid_penable", apb.penable, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        chk("rst_mid_link", link_up, 0);
        chk("rst_mid_poll_count", poll_count, 0);
        chk("rst_mid_timeout_count", timeout_count, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 0);
        rst      = 1'b0;
        cfg_hang = 1'b0;
        seen     = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || apb.psel) seen++;
        end
        chk("no_activity_after_rst", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_remote_poller.md
Name: apb_remote_poller

Overview:
- APB requester engine driving the completer-side APB port of the GTY APB bridge, i.e. issuing transactions across the SFP link to the Artix board.
- Serves a simple host command channel.
- Autonomously reads a heartbeat register at a fixed interval, with an access timeout, so the link never hangs.
- Derives a link-alive status from consecutive heartbeat results; sits directly upstream of the bridge in the bridge TX clock domain.

Parameters:
- POLL_INTERVAL, 156250, clk cycles between heartbeat reads (1 ms at 156.25 MHz); min 2.
- POLL_ADDR, 32'h0000_0000, heartbeat register address.
- TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles before abort; min 2.
- FAIL_THRESHOLD, 3, consecutive heartbeat failures that drop link_up; min 1.

Ports:
- clk in 1: single clock, bridge APB clock.
- rst in 1: synchronous, active-high reset.
- poll_en in 1: enables heartbeat polling.
- cmd_valid in 1, cmd_ready out 1: host command handshake.
- cmd_write in 1, cmd_addr in 32, cmd_wdata in 32: host command payload.
- rsp_valid out 1: one-cycle response pulse, no backpressure.
- rsp_rdata out 32, rsp_err out 1, rsp_timeout out 1, rsp_is_poll out 1: response payload.
- paddr out 32, psel out 1, penable out 1, pwrite out 1, pwdata out 32, pstrb out 4: APB requester outputs.
- pready in 1, prdata in 32, pslverr in 1: APB completer returns.
- link_up out 1, poll_count out 16, timeout_count out 16: status.

Behaviour:
- Reset values: all outputs 0, including cmd_ready, psel, penable, rsp_*, link_up and counters. State IDLE, poll timer loaded with POLL_INTERVAL-1, poll_pending 0.
- State machine IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - cmd_valid has priority: latch addr/write/wdata, go to SETUP.
  - Else if poll_pending: latch POLL_ADDR as a read, clear poll_pending, go to SETUP.
- SETUP: psel=1, penable=0, for exactly one cycle.
- ACCESS:
  - psel=1, penable=1. Timeout counter starts at 0 on entry.
  - pready=1: capture prdata/pslverr, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without pready: drop psel/penable, set timeout flag, go to DONE.
  - pready arriving on the same cycle as expiry counts as success.
- DONE: rsp_valid=1 for one cycle, then IDLE.
  - rsp_rdata = captured prdata; 0 for writes and timeouts.
  - rsp_err = pslverr; 0 on timeout.
  - rsp_timeout set only on abort.
  - rsp_is_poll marks heartbeat transactions.
- Latency: cmd accept to rsp_valid = 3 + N cycles, where N is the number of ACCESS wait cycles before pready (zero-wait completer gives 3).
- APB outputs: paddr/pwrite/pwdata held stable from SETUP through ACCESS. pstrb = 4'hF for writes, 4'h0 for reads. pwdata = 0 for reads.
- Poll timer:
  - Decrements every cycle while poll_en=1; at 0 sets poll_pending and reloads.
  - A second expiry while a poll is pending is dropped, not queued.
  - poll_en=0 holds the timer at reload value and clears poll_pending; an in-flight poll completes normally.
- link_up and fail counter (heartbeat results only; host commands never affect them):
  - Heartbeat success (pready & !pslverr) sets link_up=1 and clears the fail counter.
  - Heartbeat failure (pslverr or timeout) increments the fail counter, saturating at FAIL_THRESHOLD; link_up=0 once it equals FAIL_THRESHOLD.
- Status counters:
  - poll_count increments on every heartbeat completion and wraps at 16 bits.
  - timeout_count increments on any timeout, host or poll, and saturates at 16'hFFFF.
- rst mid-transaction: psel/penable drop on the next edge, no response is emitted, all state returns to reset values.

Decomposition:
- Package apb_poller_pkg:
  - state enum (IDLE, SETUP, ACCESS, DONE).
  - request struct (addr, wdata, write, is_poll).
  - APB_STRB_ALL = 4'hF.
- Sub-module apb_poll_timer: reload down-counter with enable and single-cycle expiry pulse; instantiated once.

Test Plan (POLL_INTERVAL=100, TIMEOUT_CYCLES=16, FAIL_THRESHOLD=3):
- Host read addr 32'h0000_0040, zero-wait completer returning 32'hDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_is_poll=0.
- Host write addr 32'h10, wdata 32'h1234_5678, pready delayed 5 cycles -> pstrb=4'hF, paddr/pwdata stable for all 6 ACCESS cycles, rsp_valid at cycle 8.
- poll_en=1, completer OKAY -> reads of POLL_ADDR every 100 cycles, link_up=1 after the first, poll_count=3 after ~300 cycles.
- pready held low -> abort after 16 ACCESS cycles with rsp_timeout=1, timeout_count+1. Three consecutive failed polls drop link_up to 0; one subsequent success restores it.
- cmd_valid asserted on the same cycle poll_pending is set -> host command issued first, poll follows immediately after DONE, no poll lost.
- rst asserted mid-ACCESS -> psel=0 next cycle, no rsp_valid, link_up=0, counters=0.
